// File: rtl/rob_commit.sv
// Reorder buffer: tail allocation, CDB completion, in-order head retirement, mispredict flush.
// Optional macro ROB_CDB_BYPASS_EN lets a CDB broadcast to the head entry retire on the same edge.
module rob_commit #(
    parameter int              ROB_DEPTH = 8,
    parameter int              TAG_W     = 3,
    parameter int              DATA_W    = 16,
    parameter int              REG_W     = 4,
    parameter int              FUNC_W    = 4,
    parameter logic [FUNC_W-1:0] BR_FUNC = 4'b1100
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic [FUNC_W-1:0] alloc_func,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic [TAG_W-1:0]  q_tag,
    output logic              q_ready,
    output logic [DATA_W-1:0] q_value,
    output logic              commit_valid,
    output logic              commit_we,
    output logic [REG_W-1:0]  commit_rd,
    output logic [DATA_W-1:0] commit_value,
    output logic [TAG_W-1:0]  commit_tag,
    output logic              flush_out,
    output logic [TAG_W:0]    count
);

    localparam logic [TAG_W:0]   DEPTH_C = (TAG_W+1)'(ROB_DEPTH);
    localparam logic [TAG_W:0]   CNT_ONE = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] PTR_ONE = TAG_W'(1);

    logic [ROB_DEPTH-1:0] busy_q, busy_d;
    logic [ROB_DEPTH-1:0] done_q, done_d;
    logic [FUNC_W-1:0]    func_q  [ROB_DEPTH];
    logic [FUNC_W-1:0]    func_d  [ROB_DEPTH];
    logic [REG_W-1:0]     rd_q    [ROB_DEPTH];
    logic [REG_W-1:0]     rd_d    [ROB_DEPTH];
    logic [DATA_W-1:0]    value_q [ROB_DEPTH];
    logic [DATA_W-1:0]    value_d [ROB_DEPTH];

    logic [TAG_W-1:0]  head_q, head_d;
    logic [TAG_W-1:0]  tail_q, tail_d;
    logic [TAG_W:0]    count_q, count_d;

    logic              cvalid_q, cvalid_d;
    logic              cwe_q, cwe_d;
    logic [REG_W-1:0]  crd_q, crd_d;
    logic [DATA_W-1:0] cval_q, cval_d;
    logic [TAG_W-1:0]  ctag_q, ctag_d;
    logic              flush_q, flush_d;

    logic              alloc_fire;
    logic              head_ready;
    logic              bypass_hit;
    logic              commit_fire;
    logic              is_branch;
    logic              mispredict;
    logic [DATA_W-1:0] retire_val;

    always_comb begin
        alloc_ready = (count_q < DEPTH_C) && !flush_q;
        alloc_fire  = alloc_valid && alloc_ready;
        alloc_tag   = tail_q;
        q_ready     = busy_q[q_tag] && done_q[q_tag];
        q_value     = q_ready ? value_q[q_tag] : '0;
        head_ready  = busy_q[head_q] && done_q[head_q];
`ifdef ROB_CDB_BYPASS_EN
        bypass_hit  = busy_q[head_q] && !done_q[head_q] && cdb_valid && (cdb_tag == head_q);
`else
        bypass_hit  = 1'b0;
`endif
        commit_fire = head_ready || bypass_hit;
        retire_val  = bypass_hit ? cdb_value : value_q[head_q];
        is_branch   = (func_q[head_q] == BR_FUNC);
        mispredict  = commit_fire && is_branch && retire_val[0];
    end

    always_comb begin
        busy_d   = busy_q;
        done_d   = done_q;
        func_d   = func_q;
        rd_d     = rd_q;
        value_d  = value_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        cvalid_d = 1'b0;
        cwe_d    = 1'b0;
        crd_d    = crd_q;
        cval_d   = cval_q;
        ctag_d   = ctag_q;
        flush_d  = 1'b0;

        if (commit_fire) begin
            cvalid_d = 1'b1;
            cwe_d    = !is_branch;
            crd_d    = rd_q[head_q];
            cval_d   = retire_val;
            ctag_d   = head_q;
        end

        if (mispredict) begin
            // A same-edge allocation is dropped along with everything else.
            busy_d  = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            flush_d = 1'b1;
        end else begin
            if (alloc_fire) begin
                busy_d[tail_q]  = 1'b1;
                done_d[tail_q]  = 1'b0;
                func_d[tail_q]  = alloc_func;
                rd_d[tail_q]    = alloc_rd;
                value_d[tail_q] = '0;
                tail_d          = tail_q + PTR_ONE;
            end
            // Uses pre-edge busy, so a CDB to the slot being allocated is ignored.
            if (cdb_valid && busy_q[cdb_tag] && !done_q[cdb_tag]) begin
                done_d[cdb_tag]  = 1'b1;
                value_d[cdb_tag] = cdb_value;
            end
            if (commit_fire) begin
                busy_d[head_q] = 1'b0;
                done_d[head_q] = 1'b0;
                head_d         = head_q + PTR_ONE;
            end
            if (alloc_fire && !commit_fire) begin
                count_d = count_q + CNT_ONE;
            end else if (!alloc_fire && commit_fire) begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            busy_q   <= '0;
            done_q   <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                func_q[i]  <= '0;
                rd_q[i]    <= '0;
                value_q[i] <= '0;
            end
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            cvalid_q <= 1'b0;
            cwe_q    <= 1'b0;
            crd_q    <= '0;
            cval_q   <= '0;
            ctag_q   <= '0;
            flush_q  <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                func_q[i]  <= func_d[i];
                rd_q[i]    <= rd_d[i];
                value_q[i] <= value_d[i];
            end
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            cvalid_q <= cvalid_d;
            cwe_q    <= cwe_d;
            crd_q    <= crd_d;
            cval_q   <= cval_d;
            ctag_q   <= ctag_d;
            flush_q  <= flush_d;
        end
    end

    assign commit_valid = cvalid_q;
    assign commit_we    = cwe_q;
    assign commit_rd    = crd_q;
    assign commit_value = cval_q;
    assign commit_tag   = ctag_q;
    assign flush_out    = flush_q;
    assign count        = count_q;

endmodule

// File: tb/tb_rob_commit.sv
// Bench for rob_commit: vector table, hand-written corner sequences and a random run
// checked against a queue-based model of the reorder buffer.
module tb_rob_commit;

    localparam int          DEPTH = 8;
    localparam int          TW    = 3;
    localparam int          DW    = 16;
    localparam int          RW    = 4;
    localparam int          FW    = 4;
    localparam logic [FW-1:0] BR  = 4'b1100;

    logic          clk1 = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [FW-1:0] alloc_func;
    logic [RW-1:0] alloc_rd;
    logic [TW-1:0] alloc_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_value;
    logic [TW-1:0] q_tag;
    logic          q_ready;
    logic [DW-1:0] q_value;
    logic          commit_valid;
    logic          commit_we;
    logic [RW-1:0] commit_rd;
    logic [DW-1:0] commit_value;
    logic [TW-1:0] commit_tag;
    logic          flush_out;
    logic [TW:0]   count;

    always #5 clk1 = ~clk1;

    rob_commit dut (
        .clk1(clk1), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_func(alloc_func), .alloc_rd(alloc_rd), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .q_tag(q_tag), .q_ready(q_ready), .q_value(q_value),
        .commit_valid(commit_valid), .commit_we(commit_we), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_tag(commit_tag),
        .flush_out(flush_out), .count(count)
    );

    // Model: in-flight instructions in program order, each carrying its tag.
    typedef struct {
        logic [TW-1:0] tag;
        logic [FW-1:0] func;
        logic [RW-1:0] rd;
        logic [DW-1:0] value;
        bit            done;
    } ment_t;

    ment_t         mq[$];
    int            m_head;
    bit            m_flush;
    bit            m_cvalid, m_cwe;
    logic [RW-1:0] m_crd;
    logic [DW-1:0] m_cval;
    logic [TW-1:0] m_ctag;

    int tests = 0;
    int fails = 0;

    logic          pre_ready;
    logic [TW-1:0] pre_atag;
    logic          pre_qrdy;
    logic [DW-1:0] pre_qval;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit av, input logic [FW-1:0] af, input logic [RW-1:0] ard,
                        input bit cv, input logic [TW-1:0] ct, input logic [DW-1:0] cval,
                        input logic [TW-1:0] qt);
        bit            e_ready, e_qrdy, commit, fire;
        logic [TW-1:0] e_atag;
        logic [DW-1:0] e_qval, rv;
        ment_t         ne;
        rst = r; alloc_valid = av; alloc_func = af; alloc_rd = ard;
        cdb_valid = cv; cdb_tag = ct; cdb_value = cval; q_tag = qt;
        #1;
        e_ready = (mq.size() < DEPTH) && !m_flush;
        e_atag  = TW'((m_head + mq.size()) % DEPTH);
        e_qrdy  = 1'b0;
        e_qval  = '0;
        foreach (mq[i]) if (mq[i].tag == qt && mq[i].done) begin
            e_qrdy = 1'b1;
            e_qval = mq[i].value;
        end
        pre_ready = alloc_ready; pre_atag = alloc_tag; pre_qrdy = q_ready; pre_qval = q_value;
        check("alloc_ready", alloc_ready, e_ready);
        check("alloc_tag", alloc_tag, e_atag);
        check("q_ready", q_ready, e_qrdy);
        check("q_value", q_value, e_qval);

        if (r) begin
            mq.delete();
            m_head = 0; m_flush = 0; m_cvalid = 0; m_cwe = 0;
            m_crd = '0; m_cval = '0; m_ctag = '0;
        end else begin
            commit = 1'b0;
            rv     = '0;
            if (mq.size() > 0) begin
                if (mq[0].done) begin
                    commit = 1'b1;
                    rv     = mq[0].value;
                end
`ifdef ROB_CDB_BYPASS_EN
                else if (cv && ct == mq[0].tag) begin
                    commit = 1'b1;
                    rv     = cval;
                end
`endif
            end
            fire     = av && e_ready;
            m_cvalid = commit;
            m_cwe    = commit && (mq[0].func != BR);
            if (commit) begin
                m_crd  = mq[0].rd;
                m_cval = rv;
                m_ctag = mq[0].tag;
            end
            m_flush = commit && (mq[0].func == BR) && rv[0];
            if (m_flush) begin
                mq.delete();
                m_head = 0;
            end else begin
                foreach (mq[i]) if (cv && mq[i].tag == ct && !mq[i].done) begin
                    mq[i].done  = 1'b1;
                    mq[i].value = cval;
                end
                if (commit) begin
                    void'(mq.pop_front());
                    m_head = (m_head + 1) % DEPTH;
                end
                if (fire) begin
                    ne.tag = e_atag; ne.func = af; ne.rd = ard; ne.value = '0; ne.done = 1'b0;
                    mq.push_back(ne);
                end
            end
        end

        @(posedge clk1);
        #1;
        check("count", count, mq.size());
        check("commit_valid", commit_valid, m_cvalid);
        check("commit_we", commit_we, m_cwe);
        check("commit_rd", commit_rd, m_crd);
        check("commit_value", commit_value, m_cval);
        check("commit_tag", commit_tag, m_ctag);
        check("flush_out", flush_out, m_flush);
    endtask

    typedef struct {
        bit            av;
        logic [FW-1:0] af;
        logic [RW-1:0] ard;
        bit            cv;
        logic [TW-1:0] ct;
        logic [DW-1:0] cval;
        logic [TW-1:0] qt;
        bit            e_ready;
        logic [TW-1:0] e_atag;
        bit            e_qrdy;
        logic [DW-1:0] e_qval;
        bit            e_cvalid;
        logic [RW-1:0] e_crd;
        logic [DW-1:0] e_cvalue;
        logic [TW:0]   e_count;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int seen;
        // av  af ard cv ct cval    qt | rdy atag qrdy qval   | cvalid crd cvalue  cnt
        tbl[0] = '{1, 0, 1, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 0, 0, 16'h0000, 1};
        tbl[1] = '{1, 0, 2, 0, 0, 16'h0000, 0, 1, 1, 0, 16'h0000, 0, 0, 16'h0000, 2};
        tbl[2] = '{1, 0, 3, 0, 0, 16'h0000, 0, 1, 2, 0, 16'h0000, 0, 0, 16'h0000, 3};
        tbl[3] = '{0, 0, 0, 1, 1, 16'h00AA, 1, 1, 3, 0, 16'h0000, 0, 0, 16'h0000, 3};
`ifdef ROB_CDB_BYPASS_EN
        tbl[4] = '{0, 0, 0, 1, 0, 16'h0055, 1, 1, 3, 1, 16'h00AA, 1, 1, 16'h0055, 2};
        tbl[5] = '{0, 0, 0, 0, 0, 16'h0000, 1, 1, 3, 1, 16'h00AA, 1, 2, 16'h00AA, 1};
        tbl[6] = '{0, 0, 0, 0, 0, 16'h0000, 2, 1, 3, 0, 16'h0000, 0, 2, 16'h00AA, 1};
`else
        tbl[4] = '{0, 0, 0, 1, 0, 16'h0055, 1, 1, 3, 1, 16'h00AA, 0, 0, 16'h0000, 3};
        tbl[5] = '{0, 0, 0, 0, 0, 16'h0000, 1, 1, 3, 1, 16'h00AA, 1, 1, 16'h0055, 2};
        tbl[6] = '{0, 0, 0, 0, 0, 16'h0000, 2, 1, 3, 0, 16'h0000, 1, 2, 16'h00AA, 1};
`endif
        tbl[7] = '{0, 0, 0, 0, 0, 16'h0000, 2, 1, 3, 0, 16'h0000, 0, 2, 16'h00AA, 1};

        rst = 1'b1; alloc_valid = 0; alloc_func = '0; alloc_rd = '0;
        cdb_valid = 0; cdb_tag = '0; cdb_value = '0; q_tag = '0;
        mq.delete(); m_head = 0; m_flush = 0; m_cvalid = 0; m_cwe = 0;
        m_crd = '0; m_cval = '0; m_ctag = '0;
        repeat (2) @(posedge clk1);
        #1;
        rst = 1'b0;
        #1;
        check("reset count", count, 0);
        check("reset commit_valid", commit_valid, 0);
        check("reset flush_out", flush_out, 0);
        check("reset alloc_ready", alloc_ready, 1);
        check("reset alloc_tag", alloc_tag, 0);

        // Basic allocate / out-of-order complete / in-order retire
        for (int i = 0; i < 8; i++) begin
            step(0, tbl[i].av, tbl[i].af, tbl[i].ard, tbl[i].cv, tbl[i].ct, tbl[i].cval, tbl[i].qt);
            check($sformatf("tbl%0d ready", i), pre_ready, tbl[i].e_ready);
            check($sformatf("tbl%0d atag", i), pre_atag, tbl[i].e_atag);
            check($sformatf("tbl%0d qrdy", i), pre_qrdy, tbl[i].e_qrdy);
            check($sformatf("tbl%0d qval", i), pre_qval, tbl[i].e_qval);
            check($sformatf("tbl%0d cvalid", i), commit_valid, tbl[i].e_cvalid);
            check($sformatf("tbl%0d crd", i), commit_rd, tbl[i].e_crd);
            check($sformatf("tbl%0d cvalue", i), commit_value, tbl[i].e_cvalue);
            check($sformatf("tbl%0d count", i), count, tbl[i].e_count);
        end

        // Full buffer and pointer wrap
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 1, 4'h1, RW'(i), 0, 0, 0, 0);
        check("full count", count, 8);
        step(0, 1, 4'h1, 4'hF, 0, 0, 0, 0);
        check("full ready", pre_ready, 0);
        check("full 9th ignored", count, 8);
        step(0, 1, 4'h1, 4'hF, 1, 0, 16'h1234, 0);
        seen = commit_valid ? 1 : 0;
        for (int k = 0; k < 3 && seen == 0; k++) begin
            step(0, 1, 4'h1, 4'hF, 0, 0, 0, 0);
            seen = commit_valid ? 1 : 0;
        end
        check("full commit seen", seen, 1);
        check("full commit value", commit_value, 16'h1234);
        check("full same-cycle alloc rejected", count, 7);
        step(0, 1, 4'h2, 4'hE, 0, 0, 0, 0);
        check("wrap ready", pre_ready, 1);
        check("wrap tag", pre_atag, 0);
        check("wrap count", count, 8);

        // Mispredicted branch flush
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(0, 1, BR, 4'h5, 0, 0, 0, 0);
        step(0, 1, 4'h1, 4'h6, 0, 0, 0, 0);
        step(0, 1, 4'h1, 4'h7, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 16'h0001, 0);
        seen = commit_valid ? 1 : 0;
        for (int k = 0; k < 3 && seen == 0; k++) begin
            step(0, 0, 0, 0, 0, 0, 0, 0);
            seen = commit_valid ? 1 : 0;
        end
        check("br commit seen", seen, 1);
        check("br commit_we", commit_we, 0);
        check("br flush_out", flush_out, 1);
        check("br count", count, 0);
        step(0, 1, 4'h1, 4'h8, 0, 0, 0, 0);
        check("br ready during flush", pre_ready, 0);
        check("br alloc dropped", count, 0);
        step(0, 1, 4'h1, 4'h8, 0, 0, 0, 0);
        check("br next tag", pre_atag, 0);
        check("br next count", count, 1);

        // Reset with busy entries
        step(1, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 4'h3, RW'(i + 1), 0, 0, 0, 0);
        check("pre-reset count", count, 4);
        step(1, 0, 0, 0, 1, 0, 16'h00FF, 0);
        check("mid reset count", count, 0);
        check("mid reset commit_valid", commit_valid, 0);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            logic [FW-1:0] rf;
            rf = ($urandom_range(0, 5) == 0) ? BR : FW'($urandom_range(0, 15));
            step(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6), rf,
                 RW'($urandom), ($urandom_range(0, 1) == 1), TW'($urandom),
                 DW'($urandom), TW'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
